// File: rtl/pc_unit_if.sv
// pc_unit_if: request/response bundle between the cpu control decoder and
// the program-counter unit. The decoder drives the requests and the offset;
// the unit returns the current PC and the return-address-stack status.
interface pc_unit_if #(
  parameter int PC_W     = 32,
  parameter int OFFSET_W = 8
);
  logic                STALL;
  logic                JUMP;
  logic                BRANCH;
  logic                ZERO;
  logic                CALL;
  logic                RET;
  logic [OFFSET_W-1:0] OFFSET;
  logic [PC_W-1:0]     PC;
  logic                RAS_EMPTY;
  logic                RAS_FULL;
  logic                RAS_OVF;
  logic                RAS_UNF;

  modport master (
    output STALL, JUMP, BRANCH, ZERO, CALL, RET, OFFSET,
    input  PC, RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF
  );

  modport slave (
    input  STALL, JUMP, BRANCH, ZERO, CALL, RET, OFFSET,
    output PC, RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with stall, relative jump, branch-if-zero and
// optional CALL/RET through a circular return-address stack.
// Optional feature macro: PC_RAS_EN (defined -> stack built; undefined ->
// CALL acts as JUMP, RET acts as a plain increment, RAS status tied off).
// Request priority per edge: STALL > RET > CALL > JUMP > BRANCH&ZERO > increment.
module pc_unit #(
  parameter int PC_W      = 32,
  parameter int OFFSET_W  = 8,
  parameter int STEP      = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic      CLK,
  input  logic      RESET,
  pc_unit_if.slave  bus
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] target;

  // Offset counts instructions, so it is sign-extended then scaled by STEP;
  // all arithmetic wraps silently at PC_W bits.
  assign off_ext = {{(PC_W-OFFSET_W){bus.OFFSET[OFFSET_W-1]}}, bus.OFFSET};
  assign pc_next = pc_q + PC_W'(STEP);
  assign target  = pc_next + off_ext * PC_W'(STEP);

  assign bus.PC = pc_q;

`ifdef PC_RAS_EN
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]   wp_q;
  logic [AW-1:0]   top_idx;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  logic            unf_q;
  logic            ras_empty;
  logic            ras_full;
  logic            push;
  logic            pop;
  logic            set_ovf;
  logic            set_unf;

  // wp_q points at the next free slot; when full it also points at the
  // oldest entry, so a push while full overwrites exactly that one.
  assign top_idx   = wp_q - AW'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

  assign bus.RAS_EMPTY = ras_empty;
  assign bus.RAS_FULL  = ras_full;
  assign bus.RAS_OVF   = ovf_q;
  assign bus.RAS_UNF   = unf_q;

  // Next-PC selection and stack operation decode.
  always_comb begin
    pc_d    = pc_next;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (bus.STALL) begin
      pc_d = pc_q;
    end else if (bus.RET) begin
      if (!ras_empty) begin
        pc_d = ras_mem[top_idx];
        pop  = 1'b1;
      end else begin
        set_unf = 1'b1;
      end
    end else if (bus.CALL) begin
      pc_d    = target;
      push    = 1'b1;
      set_ovf = ras_full;
    end else if (bus.JUMP) begin
      pc_d = target;
    end else if (bus.BRANCH && bus.ZERO) begin
      pc_d = target;
    end
  end

  // Stack storage is data only; validity is tracked by cnt_q, so no reset.
  always_ff @(posedge CLK) begin
    if (push && !RESET) begin
      ras_mem[wp_q] <= pc_next;
    end
  end

  // Stack pointer, occupancy and sticky error flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push) begin
        wp_q <= wp_q + AW'(1);
        if (!ras_full) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else if (pop) begin
        wp_q  <= top_idx;
        cnt_q <= cnt_q - CW'(1);
      end
      if (set_ovf) begin
        ovf_q <= 1'b1;
      end
      if (set_unf) begin
        unf_q <= 1'b1;
      end
    end
  end
`else
  assign bus.RAS_EMPTY = 1'b1;
  assign bus.RAS_FULL  = 1'b0;
  assign bus.RAS_OVF   = 1'b0;
  assign bus.RAS_UNF   = 1'b0;

  // Next-PC selection without a stack: RET is a plain step, CALL a jump.
  always_comb begin
    pc_d = pc_next;
    if (bus.STALL) begin
      pc_d = pc_q;
    end else if (bus.RET) begin
      pc_d = pc_next;
    end else if (bus.CALL || bus.JUMP) begin
      pc_d = target;
    end else if (bus.BRANCH && bus.ZERO) begin
      pc_d = target;
    end
  end
`endif

  // Program counter register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table-driven vectors, directed corner sequences and random
// stimulus compared against a queue-based reference model.
module tb_pc_unit;
  localparam int PC_W      = 32;
  localparam int OFFSET_W  = 8;
  localparam int STEP      = 4;
  localparam int RAS_DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  pc_unit_if #(.PC_W(PC_W), .OFFSET_W(OFFSET_W)) bus ();

  pc_unit #(
    .PC_W(PC_W), .OFFSET_W(OFFSET_W), .STEP(STEP), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: PC as a number, the stack as a queue.
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  bit          m_ovf;
  bit          m_unf;

  typedef struct {
    bit          stall, jump, branch, zero, call, ret;
    logic [7:0]  off;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 32'd0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_edge(bit s, bit j, bit b, bit z, bit c, bit r,
                                     logic [7:0] off);
    logic [31:0] nxt;
    logic [31:0] tgt;
    int          soff;
    if (s) return;
    soff = $signed(off);
    nxt  = m_pc + 32'd4;
    tgt  = nxt + 32'(soff * 4);
    if (r) begin
      if (!RAS_EN) m_pc = nxt;
      else if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_pc  = nxt;
        m_unf = 1'b1;
      end
    end else if (c) begin
      if (RAS_EN) begin
        if (m_stack.size() == RAS_DEPTH) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
        m_stack.push_back(nxt);
      end
      m_pc = tgt;
    end else if (j || (b && z)) begin
      m_pc = tgt;
    end else begin
      m_pc = nxt;
    end
  endfunction

  task automatic compare_all(string tag);
    bit e_empty, e_full;
    e_empty = !RAS_EN || (m_stack.size() == 0);
    e_full  = RAS_EN && (m_stack.size() == RAS_DEPTH);
    chk({tag, "_pc"},    bus.PC,                m_pc);
    chk({tag, "_empty"}, 32'(bus.RAS_EMPTY),    32'(e_empty));
    chk({tag, "_full"},  32'(bus.RAS_FULL),     32'(e_full));
    chk({tag, "_ovf"},   32'(bus.RAS_OVF),      32'(m_ovf));
    chk({tag, "_unf"},   32'(bus.RAS_UNF),      32'(m_unf));
  endtask

  // Drive one request set, let one edge act on it, compare #1 after.
  task automatic step(string tag, bit s, bit j, bit b, bit z, bit c, bit r,
                      logic [7:0] off);
    bus.STALL  = s;
    bus.JUMP   = j;
    bus.BRANCH = b;
    bus.ZERO   = z;
    bus.CALL   = c;
    bus.RET    = r;
    bus.OFFSET = off;
    @(posedge clk);
    #1;
    model_edge(s, j, b, z, c, r, off);
    compare_all(tag);
  endtask

  // Reset must act immediately and hold PC at 0 across an edge.
  task automatic do_reset(string tag);
    rst = 1'b1;
    #2;
    model_reset();
    compare_all({tag, "_async"});
    @(posedge clk);
    #1;
    compare_all({tag, "_held"});
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0,0,0,0,0,0,8'h00,32'd4};
    tbl[1]  = '{0,0,0,0,0,0,8'h00,32'd8};
    tbl[2]  = '{0,1,0,0,0,0,8'hFE,32'd4};
    tbl[3]  = '{0,0,0,0,0,0,8'h00,32'd8};
    tbl[4]  = '{0,0,1,0,0,0,8'h03,32'd12};
    tbl[5]  = '{0,1,0,0,0,0,8'hFE,32'd8};
    tbl[6]  = '{0,0,1,1,0,0,8'h03,32'd24};
    tbl[7]  = '{1,1,0,0,0,0,8'h05,32'd24};
    tbl[8]  = '{0,1,0,0,0,0,8'hFD,32'd16};
    tbl[9]  = '{1,1,0,0,0,0,8'h07,32'd16};
    tbl[10] = '{1,1,0,0,0,0,8'h07,32'd16};
    tbl[11] = '{1,1,0,0,0,0,8'h07,32'd16};
    tbl[12] = '{0,0,0,0,0,0,8'h07,32'd20};
    tbl[13] = '{0,1,1,1,0,0,8'h01,32'd28};
    tbl[14] = '{1,0,1,1,0,0,8'h01,32'd28};
    tbl[15] = '{0,1,0,0,0,0,8'h7F,32'd540};
    tbl[16] = '{0,1,0,0,0,0,8'h80,32'd32};

    bus.STALL = 0; bus.JUMP = 0; bus.BRANCH = 0; bus.ZERO = 0;
    bus.CALL = 0; bus.RET = 0; bus.OFFSET = '0;
    model_reset();

    // Power-on reset pulse t=7..12, then free-running increments.
    #7 rst = 1'b1;
    #1 compare_all("por");
    #4 rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step("run", 0,0,0,0,0,0, 8'h00);
      chk("run_pc_const", bus.PC, 32'(4 * i));
    end
    do_reset("midrun");

    // Jump / branch / stall vectors.
    foreach (tbl[i]) begin
      step("tbl", tbl[i].stall, tbl[i].jump, tbl[i].branch, tbl[i].zero,
           tbl[i].call, tbl[i].ret, tbl[i].off);
      chk("tbl_pc_const", bus.PC, tbl[i].pc);
      chk("tbl_empty_const", 32'(bus.RAS_EMPTY), 32'd1);
    end

    // Wrap-around: 0 -> FFFFFFFC -> 0.
    do_reset("wrap");
    step("wrap_jump", 0,1,0,0,0,0, 8'hFE);
    chk("wrap_top", bus.PC, 32'hFFFF_FFFC);
    step("wrap_inc", 0,0,0,0,0,0, 8'h00);
    chk("wrap_zero", bus.PC, 32'd0);

    // CALL+RET together with empty stack: RET wins, no push.
    step("callret", 0,0,0,0,1,1, 8'h05);
    chk("callret_pc", bus.PC, 32'd4);
    chk("callret_unf", 32'(bus.RAS_UNF), 32'(RAS_EN));
    chk("callret_empty", 32'(bus.RAS_EMPTY), 32'd1);

    // Single CALL/RET and underflow.
    do_reset("call");
    step("call1", 0,0,0,0,1,0, 8'h04);
    chk("call1_pc", bus.PC, 32'd20);
    step("ret1", 0,0,0,0,0,1, 8'h00);
    chk("ret1_pc", bus.PC, RAS_EN ? 32'd4 : 32'd24);
    step("ret2", 0,0,0,0,0,1, 8'h00);
    chk("ret2_pc", bus.PC, RAS_EN ? 32'd8 : 32'd28);

    // Nested CALLs past the depth, then unwind.
    do_reset("nest");
    for (int i = 1; i <= 5; i++) step("nest_call", 0,0,0,0,1,0, 8'h00);
    chk("nest_full", 32'(bus.RAS_FULL), 32'(RAS_EN));
    chk("nest_ovf", 32'(bus.RAS_OVF), 32'(RAS_EN));
    for (int i = 0; i < 4; i++) begin
      step("nest_ret", 0,0,0,0,0,1, 8'h00);
      chk("nest_ret_pc", bus.PC, RAS_EN ? 32'(20 - 4 * i) : 32'(24 + 4 * i));
    end
    step("nest_unf", 0,0,0,0,0,1, 8'h00);
    chk("nest_unf_flag", 32'(bus.RAS_UNF), 32'(RAS_EN));

    // Stalled CALL/RET must not touch the stack.
    do_reset("stallras");
    step("sr_call", 0,0,0,0,1,0, 8'h02);
    step("sr_stall_ret", 1,0,0,0,0,1, 8'h00);
    step("sr_stall_call", 1,0,0,0,1,0, 8'h00);
    step("sr_ret", 0,0,0,0,0,1, 8'h00);

    // Random stimulus against the model.
    do_reset("rand");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rand_rst");
      end else begin
        step("rand",
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 0,
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 4) == 0,
             8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
